// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DATA_W      = 32;
  localparam int LAT_DEFAULT = 2;
  localparam int CNT_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              d_req;
  logic              d_we;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters and memory model side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between a fetch and a data requester,
// round-robin on ties. LAT is the memory read latency, legal range 1..7.
//
// state    | meaning
// ST_IDLE  | sample requests, grant one and latch its command
// ST_ISSUE | one-cycle memory strobe from the latched command
// ST_WAIT  | count down the read latency, capture rdata at cnt == 0
// ST_RESP  | one-cycle valid pulse to the owner, no request sampling
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LAT = LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  owner_e            grant;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant        = OWN_IF;

    // On a tie the requester not granted last wins
    if (bus.if_req && bus.d_req) begin
      grant = (last_owner_q == OWN_IF) ? OWN_D : OWN_IF;
    end else if (bus.d_req) begin
      grant = OWN_D;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          owner_d      = grant;
          last_owner_d = grant;
          we_d         = (grant == OWN_D) && bus.d_we;
          addr_d       = (grant == OWN_D) ? bus.d_addr : bus.if_addr;
          wdata_d      = (grant == OWN_D) ? bus.d_wdata : '0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_RESP;
        end else begin
          cnt_d   = CNT_W'(LAT - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q == OWN_D) d_rdata_d  = bus.mem_rdata;
          else                  if_rdata_d = bus.mem_rdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en    = (state_q == ST_ISSUE);
    bus.mem_we    = (state_q == ST_ISSUE) && we_q;
    bus.mem_addr  = (state_q == ST_ISSUE) ? addr_q : '0;
    bus.mem_wdata = (state_q == ST_ISSUE) ? wdata_q : '0;
    bus.if_valid  = (state_q == ST_RESP) && (owner_q == OWN_IF);
    bus.d_valid   = (state_q == ST_RESP) && (owner_q == OWN_D);
    bus.if_rdata  = if_rdata_q;
    bus.d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LAT=2 main instance plus LAT=1 and LAT=7 builds.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_port_arbiter_if b1 ();
  mem_port_arbiter_if b2 ();
  mem_port_arbiter_if b7 ();

  mem_port_arbiter #(.LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  mem_port_arbiter #(.LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));
  mem_port_arbiter #(.LAT(7)) u_dut7 (.clk(clk), .rst(rst), .bus(b7));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Cycle boundary: inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0; b1.mem_rdata = 0;
    b2.if_req = 0; b2.if_addr = 0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = 0; b2.d_wdata = 0; b2.mem_rdata = 0;
    b7.if_req = 0; b7.if_addr = 0; b7.d_req = 0; b7.d_we = 0; b7.d_addr = 0; b7.d_wdata = 0; b7.mem_rdata = 0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b0;
    b2.if_req  = 1'b1;
    b2.if_addr = 32'h99;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_cmp++;
      if ({b2.mem_en, b2.mem_we, b2.if_valid, b2.d_valid} !== 4'b0 || b2.mem_addr !== 32'h0 ||
          b2.mem_wdata !== 32'h0 || b2.if_rdata !== 32'h0 || b2.d_rdata !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_outputs c%0d: got en=%b we=%b iv=%b dv=%b addr=%h wd=%h ird=%h drd=%h expected all 0",
                 c, b2.mem_en, b2.mem_we, b2.if_valid, b2.d_valid, b2.mem_addr, b2.mem_wdata,
                 b2.if_rdata, b2.d_rdata);
      end
    end
    b2.if_req  = 1'b0;
    b2.if_addr = 32'h0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_tie_after_reset;
    logic [31:0] ea;
    do_reset();
    b2.if_req = 1; b2.if_addr = 32'h100; b2.d_req = 1; b2.d_we = 0; b2.d_addr = 32'h200;
    for (int c = 1; c <= 10; c++) begin
      tick();
      b2.mem_rdata = (c == 3) ? 32'hCAFE0001 : (c == 8) ? 32'h12345678 : 32'h0;
      ea = (c == 1) ? 32'h200 : (c == 6) ? 32'h100 : 32'h0;
      n_cmp++;
      if (b2.mem_en !== (c == 1 || c == 6) || b2.mem_addr !== ea || b2.mem_we !== 1'b0) begin
        n_bad++;
        $display("FAIL tie_mem c%0d: got en=%b addr=%h we=%b expected en=%b addr=%h we=0",
                 c, b2.mem_en, b2.mem_addr, b2.mem_we, (c == 1 || c == 6), ea);
      end
      n_cmp++;
      if (b2.d_valid !== (c == 4) || b2.if_valid !== (c == 9)) begin
        n_bad++;
        $display("FAIL tie_valid c%0d: got dv=%b iv=%b expected dv=%b iv=%b",
                 c, b2.d_valid, b2.if_valid, (c == 4), (c == 9));
      end
      if (c == 4) begin
        n_cmp++;
        if (b2.d_rdata !== 32'hCAFE0001) begin
          n_bad++;
          $display("FAIL tie_d_rdata: got %h expected cafe0001", b2.d_rdata);
        end
        b2.d_req = 0;
      end
      if (c == 9) begin
        n_cmp++;
        if (b2.if_rdata !== 32'h12345678) begin
          n_bad++;
          $display("FAIL tie_if_rdata: got %h expected 12345678", b2.if_rdata);
        end
        b2.if_req = 0;
      end
    end
  endtask

  task automatic test_fetch_read;
    logic [31:0] ea;
    b2.if_req = 1; b2.if_addr = 32'h10;
    for (int c = 1; c <= 5; c++) begin
      tick();
      b2.mem_rdata = (c == 3) ? 32'hDEADBEEF : 32'h0;
      ea = (c == 1) ? 32'h10 : 32'h0;
      n_cmp++;
      if (b2.mem_en !== (c == 1) || b2.mem_addr !== ea) begin
        n_bad++;
        $display("FAIL fetch_mem c%0d: got en=%b addr=%h expected en=%b addr=%h",
                 c, b2.mem_en, b2.mem_addr, (c == 1), ea);
      end
      n_cmp++;
      if (b2.if_valid !== (c == 4) || b2.d_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL fetch_valid c%0d: got iv=%b dv=%b expected iv=%b dv=0",
                 c, b2.if_valid, b2.d_valid, (c == 4));
      end
      if (c == 4) begin
        n_cmp++;
        if (b2.if_rdata !== 32'hDEADBEEF) begin
          n_bad++;
          $display("FAIL fetch_rdata: got %h expected deadbeef", b2.if_rdata);
        end
        b2.if_req = 0;
      end
    end
  endtask

  task automatic test_data_write;
    b2.d_req = 1; b2.d_we = 1; b2.d_addr = 32'h20; b2.d_wdata = 32'h55AA;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) begin
        n_cmp++;
        if (b2.mem_en !== 1'b1 || b2.mem_we !== 1'b1 || b2.mem_addr !== 32'h20 || b2.mem_wdata !== 32'h55AA) begin
          n_bad++;
          $display("FAIL write_issue: got en=%b we=%b addr=%h wd=%h expected en=1 we=1 addr=20 wd=55aa",
                   b2.mem_en, b2.mem_we, b2.mem_addr, b2.mem_wdata);
        end
      end else begin
        n_cmp++;
        if (b2.mem_en !== 1'b0 || b2.mem_we !== 1'b0 || b2.mem_addr !== 32'h0 || b2.mem_wdata !== 32'h0) begin
          n_bad++;
          $display("FAIL write_mem_idle c%0d: got en=%b we=%b addr=%h wd=%h expected all 0",
                   c, b2.mem_en, b2.mem_we, b2.mem_addr, b2.mem_wdata);
        end
      end
      n_cmp++;
      if (b2.d_valid !== (c == 2) || b2.if_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL write_valid c%0d: got dv=%b iv=%b expected dv=%b iv=0",
                 c, b2.d_valid, b2.if_valid, (c == 2));
      end
      if (c == 2) begin
        n_cmp++;
        if (b2.d_rdata !== 32'hCAFE0001) begin
          n_bad++;
          $display("FAIL write_d_rdata_kept: got %h expected cafe0001", b2.d_rdata);
        end
        b2.d_req = 0; b2.d_we = 0;
      end
    end
  endtask

  task automatic test_tie_round_robin;
    logic [31:0] ea;
    logic        exp_d;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_d = (k != 1);
      b2.if_req = 1; b2.if_addr = 32'h100 + k; b2.d_req = 1; b2.d_we = 0; b2.d_addr = 32'h200 + k;
      for (int c = 1; c <= 5; c++) begin
        tick();
        b2.mem_rdata = (c == 3) ? 32'hA0 + k : 32'h0;
        if (c == 1) begin
          ea = exp_d ? 32'h200 + k : 32'h100 + k;
          n_cmp++;
          if (b2.mem_en !== 1'b1 || b2.mem_addr !== ea) begin
            n_bad++;
            $display("FAIL rr_grant k%0d: got en=%b addr=%h expected en=1 addr=%h", k, b2.mem_en, b2.mem_addr, ea);
          end
        end
        if (c == 4) begin
          ea = 32'hA0 + k;
          n_cmp++;
          if (b2.d_valid !== exp_d || b2.if_valid !== !exp_d ||
              (exp_d ? b2.d_rdata : b2.if_rdata) !== ea) begin
            n_bad++;
            $display("FAIL rr_resp k%0d: got dv=%b iv=%b ird=%h drd=%h expected dv=%b iv=%b rdata=%h",
                     k, b2.d_valid, b2.if_valid, b2.if_rdata, b2.d_rdata, exp_d, !exp_d, ea);
          end
          b2.if_req = 0; b2.d_req = 0;
        end
      end
    end
  endtask

  task automatic test_reset_in_wait;
    b2.if_req = 1; b2.if_addr = 32'h40;
    tick();
    n_cmp++;
    if (b2.mem_en !== 1'b1 || b2.mem_addr !== 32'h40) begin
      n_bad++;
      $display("FAIL rstw_issue: got en=%b addr=%h expected en=1 addr=40", b2.mem_en, b2.mem_addr);
    end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({b2.mem_en, b2.mem_we, b2.if_valid, b2.d_valid} !== 4'b0 || b2.mem_addr !== 32'h0 ||
        b2.mem_wdata !== 32'h0 || b2.if_rdata !== 32'h0 || b2.d_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rstw_outputs: got en=%b we=%b iv=%b dv=%b addr=%h wd=%h ird=%h drd=%h expected all 0",
               b2.mem_en, b2.mem_we, b2.if_valid, b2.d_valid, b2.mem_addr, b2.mem_wdata, b2.if_rdata, b2.d_rdata);
    end
    rst = 1'b1;
    b2.if_req = 0;
    b2.mem_rdata = 32'hBADBAD00;
    tick();
    b2.mem_rdata = 32'h0;
    n_cmp++;
    if (b2.if_valid !== 1'b0 || b2.if_rdata !== 32'h0 || b2.mem_en !== 1'b0) begin
      n_bad++;
      $display("FAIL rstw_stale: got iv=%b ird=%h en=%b expected iv=0 ird=0 en=0", b2.if_valid, b2.if_rdata, b2.mem_en);
    end
    b2.if_req = 1; b2.if_addr = 32'h44;
    for (int c = 1; c <= 5; c++) begin
      tick();
      b2.mem_rdata = (c == 3) ? 32'h0A0B0C0D : 32'h0;
      n_cmp++;
      if (b2.if_valid !== (c == 4) || b2.mem_en !== (c == 1)) begin
        n_bad++;
        $display("FAIL rstw_after c%0d: got iv=%b en=%b expected iv=%b en=%b",
                 c, b2.if_valid, b2.mem_en, (c == 4), (c == 1));
      end
      if (c == 4) begin
        n_cmp++;
        if (b2.if_rdata !== 32'h0A0B0C0D) begin
          n_bad++;
          $display("FAIL rstw_after_rdata: got %h expected 0a0b0c0d", b2.if_rdata);
        end
        b2.if_req = 0;
      end
    end
  endtask

  task automatic test_latency_builds;
    b1.if_req = 1; b1.if_addr = 32'h11;
    b7.if_req = 1; b7.if_addr = 32'h77;
    for (int c = 1; c <= 11; c++) begin
      tick();
      b1.mem_rdata = (c == 2) ? 32'h11111111 : 32'h0;
      b7.mem_rdata = (c == 8) ? 32'h77777777 : 32'h0;
      n_cmp++;
      if (b1.if_valid !== (c == 3) || b1.mem_en !== (c == 1)) begin
        n_bad++;
        $display("FAIL lat1 c%0d: got iv=%b en=%b expected iv=%b en=%b", c, b1.if_valid, b1.mem_en, (c == 3), (c == 1));
      end
      n_cmp++;
      if (b7.if_valid !== (c == 9) || b7.mem_en !== (c == 1)) begin
        n_bad++;
        $display("FAIL lat7 c%0d: got iv=%b en=%b expected iv=%b en=%b", c, b7.if_valid, b7.mem_en, (c == 9), (c == 1));
      end
      if (c == 3) begin
        n_cmp++;
        if (b1.if_rdata !== 32'h11111111) begin
          n_bad++;
          $display("FAIL lat1_rdata: got %h expected 11111111", b1.if_rdata);
        end
        b1.if_req = 0;
      end
      if (c == 9) begin
        n_cmp++;
        if (b7.if_rdata !== 32'h77777777) begin
          n_bad++;
          $display("FAIL lat7_rdata: got %h expected 77777777", b7.if_rdata);
        end
        b7.if_req = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_tie_after_reset();
    test_fetch_read();
    test_data_write();
    test_tie_round_robin();
    test_reset_in_wait();
    test_latency_builds();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning the memory read latency in cycles, legal range 1..7.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port if_req, input, 1 bit: instruction-fetch read request, held high until if_valid.
REQ-005 SHALL have port if_addr, input, 32 bits: fetch address, stable while if_req is high.
REQ-006 SHALL have port if_rdata, output, 32 bits: fetched word.
REQ-007 SHALL have port if_valid, output, 1 bit: one-cycle completion pulse for a fetch.
REQ-008 SHALL have port d_req, input, 1 bit: data-access request, held high until d_valid.
REQ-009 SHALL have port d_we, input, 1 bit: 1 means write and 0 means read; stable while d_req is high.
REQ-010 SHALL have port d_addr, input, 32 bits, and port d_wdata, input, 32 bits: data address and write data, both stable while d_req is high.
REQ-011 SHALL have port d_rdata, output, 32 bits: read data for a data read.
REQ-012 SHALL have port d_valid, output, 1 bit: one-cycle completion pulse for a data read or write.
REQ-013 SHALL have ports mem_en, output, 1 bit, and mem_we, output, 1 bit: memory access strobe and write enable.
REQ-014 SHALL have ports mem_addr, output, 32 bits, and mem_wdata, output, 32 bits: memory address and write data.
REQ-015 SHALL have port mem_rdata, input, 32 bits: read data, valid exactly LAT cycles after the mem_en cycle.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-017 SHALL sample requests only in IDLE; when any req is high, SHALL latch owner, address, we and wdata, and go to ISSUE.
REQ-018 SHALL resolve a tie (if_req and d_req both high in IDLE) round-robin: grant goes to the requester not granted last.
REQ-019 SHALL track the last-granted requester in a last_owner register, updated on every grant, reset to IF so that data wins the first tie.
REQ-020 SHALL, in ISSUE (exactly one cycle), drive mem_en=1, mem_addr and mem_wdata from the latch, and mem_we=1 only for a data write.
REQ-021 SHALL, after ISSUE, go to RESP directly for a write, and to WAIT for a read with counter cnt loaded with LAT-1.
REQ-022 SHALL, in WAIT, decrement cnt each cycle; when cnt is 0, SHALL capture mem_rdata into the owner's rdata register and go to RESP.
REQ-023 SHALL, in RESP (exactly one cycle), pulse the owner's valid, assert no other valid, and return to IDLE without sampling requests.
REQ-024 SHALL give a read request-high-to-valid latency of LAT+2 cycles and a write latency of 2 cycles; the minimum request spacing is valid plus 1 cycle.
REQ-025 SHALL hold if_rdata and d_rdata until the next read completion for that owner; a write leaves d_rdata unchanged.
REQ-026 SHALL keep mem_en, mem_we, mem_addr and mem_wdata at 0 outside ISSUE.
REQ-027 SHALL ignore a req that drops before its valid; the transaction in flight still completes and its valid pulse still occurs.

Reset
REQ-028 SHALL, with rst low at a clock edge, set state=IDLE, cnt=0, last_owner=IF, all outputs 0, and all latches 0.
REQ-029 SHALL, on a reset during ISSUE, WAIT or RESP, abandon the transaction with no valid pulse, and SHALL ignore any mem_rdata that returns afterward.

Structure
REQ-030 SHALL place the state enum, the owner encoding (IF=0, D=1), LAT_DEFAULT=2 and the data width 32 in a shared package.
REQ-031 SHALL be a single module with no sub-module; the two-way round-robin pick is inline logic.

Verification (LAT=2)
REQ-032 SHALL cover: if_req and if_addr=0x10 at cycle 0, mem_rdata=0xDEADBEEF at cycle 3 -> mem_en at cycle 1 with mem_addr=0x10, if_valid at cycle 4 with if_rdata=0xDEADBEEF, d_valid never asserted.
REQ-033 SHALL cover: d_req, d_we=1, d_addr=0x20, d_wdata=0x55AA at cycle 0 -> at cycle 1 mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x55AA; d_valid at cycle 2; d_rdata unchanged.
REQ-034 SHALL cover: if_req and d_req (read) both high immediately after reset -> data served first, d_valid at cycle 4, fetch issued at cycle 6, if_valid at cycle 9.
REQ-035 SHALL cover: tie repeated three times back-to-back -> grant order D, IF, D.
REQ-036 SHALL cover: rst low at cycle 2 during WAIT of a fetch -> no if_valid, all outputs 0 at cycle 3, a new request afterwards is served normally.
REQ-037 SHALL cover: LAT=1 and LAT=7 builds -> read latency of 3 and 9 cycles respectively.
